// File: rtl/decoder_2to4_reg_pkg.sv
// rtl/decoder_2to4_reg_pkg.sv - shared widths and decode function for the 2-to-4 decoder
// Purpose: holds SEL_W/OUT_W and onehot_dec(), the single definition of the decode rule.
// Ports: none (package).
package decoder_pkg;

  localparam int SEL_W = 2;
  localparam int OUT_W = 4;

  // An unknown select value falls through to the default arm, so the result
  // is all-zero rather than a partially decoded pattern.
  function automatic logic [OUT_W-1:0] onehot_dec(input logic [SEL_W-1:0] sel,
                                                  input logic             en);
    logic [OUT_W-1:0] r;
    r = '0;
    if (en) begin
      case (sel)
        2'b00:   r = 4'b0001;
        2'b01:   r = 4'b0010;
        2'b10:   r = 4'b0100;
        2'b11:   r = 4'b1000;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_2to4_reg_if.sv
// rtl/decoder_2to4_reg_if.sv - select/enable inputs and decoded output bundle
// Purpose: groups the decoder's data signals; clk/rst stay plain ports on the top.
// Signals: a (select MSB), b (select LSB), en (enable), y[3:0] (one-hot output),
//          y_valid (registered en, only when DECODER_VALID_EN is defined).
// Modports: master drives a/b/en and observes y; slave is the decoder side.
interface decoder_2to4_reg_if;
  import decoder_pkg::*;

  logic             a;
  logic             b;
  logic             en;
  logic [OUT_W-1:0] y;
`ifdef DECODER_VALID_EN
  logic             y_valid;

  modport master (output a, output b, output en, input y, input y_valid);
  modport slave  (input a, input b, input en, output y, output y_valid);
`else
  modport master (output a, output b, output en, input y);
  modport slave  (input a, input b, input en, output y);
`endif

endinterface

// File: rtl/decoder_2to4_reg_core.sv
// rtl/decoder_2to4_reg_core.sv - combinational 2-to-4 decode (a,b,en) -> y_next
// Purpose: pure combinational next-state logic for the registered decoder.
// Ports: a, b (select, a is weight 2), en (enable), y_next[3:0] (one-hot or zero).
module decoder_2to4_core
  import decoder_pkg::*;
(
  input  logic             a,
  input  logic             b,
  input  logic             en,
  output logic [OUT_W-1:0] y_next
);

  assign y_next = onehot_dec({a, b}, en);

endmodule

// File: rtl/decoder_2to4_reg.sv
// rtl/decoder_2to4_reg.sv - registered 2-to-4 line decoder with active-high enable
// Purpose: one-cycle registered one-hot decode of {a,b}, forced to zero when en=0.
// Ports: clk (rising-edge clock), rst (asynchronous active-high reset),
//        bus (decoder_2to4_reg_if.slave: a, b, en in; y out; y_valid out when
//        DECODER_VALID_EN is defined).
// Macro DECODER_VALID_EN: adds y_valid, a registered copy of en aligned with y.
module decoder_2to4_reg
  import decoder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  decoder_2to4_reg_if.slave     bus
);

  logic [OUT_W-1:0] core_y;
  logic [OUT_W-1:0] y_d;
  logic [OUT_W-1:0] y_q;

  decoder_2to4_core u_core (
    .a      (bus.a),
    .b      (bus.b),
    .en     (bus.en),
    .y_next (core_y)
  );

  always_comb begin
    y_d = core_y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign bus.y = y_q;

`ifdef DECODER_VALID_EN
  logic y_valid_d;
  logic y_valid_q;

  always_comb begin
    y_valid_d = bus.en;
  end

  // Same reset and latency as y_q, so y_valid=0 always coincides with y=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= y_valid_d;
    end
  end

  assign bus.y_valid = y_valid_q;
`endif

endmodule

// File: tb/tb_decoder_2to4_reg.sv
// tb/tb_decoder_2to4_reg.sv - scoreboard bench for decoder_2to4_reg
module tb_decoder_2to4_reg;

  logic clk;
  logic rst;

  decoder_2to4_reg_if bus ();

  decoder_2to4_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] y;
    logic       v;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   errors = 0;
  int   checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic ma, input logic mb, input logic men);
    exp_t r;
    int   sel;
    sel = int'(ma) * 2 + int'(mb);
    r.y = men ? 4'(1 << sel) : 4'd0;
    r.v = men;
    return r;
  endfunction

  // Inputs change on the falling edge; the rising edge that follows samples them.
  task automatic drive(input logic da, input logic db, input logic den);
    @(negedge clk);
    bus.a  = da;
    bus.b  = db;
    bus.en = den;
    sb.push_back(model(da, db, den));
  endtask

  task automatic check_now(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: y=%b required %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: each rising edge out of reset presents one decode result.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      checks++;
      if (!$onehot0(bus.y)) begin
        errors++;
        $display("FAIL onehot0: y=%b has more than one bit set at %0t", bus.y, $time);
      end
      if (sb.size() > 0) begin
        e_mon = sb.pop_front();
        checks++;
        if (bus.y !== e_mon.y) begin
          errors++;
          $display("FAIL decode: y=%b required %b at %0t", bus.y, e_mon.y, $time);
        end
`ifdef DECODER_VALID_EN
        checks++;
        if (bus.y_valid !== e_mon.v) begin
          errors++;
          $display("FAIL y_valid: y_valid=%b required %b at %0t", bus.y_valid, e_mon.v, $time);
        end
        checks++;
        if (!bus.y_valid && bus.y != 4'd0) begin
          errors++;
          $display("FAIL valid_implies_zero: y=%b required 0000 with y_valid=0", bus.y);
        end
`endif
      end
    end
  end

  initial begin
    // Reset with arbitrary inputs: output must clear before any clock edge.
    rst    = 1'b1;
    bus.a  = 1'b1;
    bus.b  = 1'b0;
    bus.en = 1'b1;
    #1;
    check_now("reset_no_edge", bus.y, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_held", bus.y, 4'b0000);

    // Release with en=0: first decode is all-zero.
    @(negedge clk);
    rst    = 1'b0;
    bus.en = 1'b0;
    sb.push_back(model(bus.a, bus.b, 1'b0));

    // Each select value with enable high.
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1);

    // Select sweep while disabled, then re-enable.
    for (int s = 0; s < 4; s++) begin
      drive(s[1], s[0], 1'b0);
    end
    drive(1'b1, 1'b0, 1'b1);

    // Reset asserted between edges clears y immediately.
    drive(1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_now("reset_mid_op", bus.y, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(model(bus.a, bus.b, bus.en));

    // Enable pattern 1,0,1.
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && sb.size() != 0; k++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
